// File: rtl/ddr_mode_pkg.sv
// Shared types and width helpers for the channel read/write mode controller.
// Optional MODE_STATS_EN adds statistics counters in channel_rw_mode_ctrl.
package ddr_mode_pkg;

    typedef enum logic [1:0] {
        MODE_READ,
        MODE_RD2WR,
        MODE_WRITE,
        MODE_WR2RD
    } mode_state_e;

    function automatic int total_w(input int depth, input int nrank);
        return $clog2(depth) + $clog2(nrank);
    endfunction

    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/queue_occupancy_sum.sv
// Sums a per-rank queue occupancy array into one channel total.
// Optional MODE_STATS_EN does not affect this block.
module queue_occupancy_sum
    import ddr_mode_pkg::*;
#(
    parameter int NUMRANK = 4,
    parameter int DEPTH   = 8,
    localparam int CW     = $clog2(DEPTH),
    localparam int TW     = total_w(DEPTH, NUMRANK)
) (
    input  logic [NUMRANK-1:0][CW-1:0] i_cnt,
    output logic [TW-1:0]              o_total
);

    logic [TW-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUMRANK; i++) begin
            w_sum = w_sum + TW'(i_cnt[i]);
        end
    end

    assign o_total = w_sum;

endmodule

// File: rtl/channel_rw_mode_ctrl.sv
// Channel READ/WRITE mode FSM with turnaround windows and write-burst bound.
// Define MODE_STATS_EN to add switchCount / starveExitCount outputs.
module channel_rw_mode_ctrl
    import ddr_mode_pkg::*;
#(
    parameter int NUMRANK            = 4,
    parameter int READCMDQUEUEDEPTH  = 8,
    parameter int WRITECMDQUEUEDEPTH = 8,
    parameter int WR_HIGH_WM         = 12,
    parameter int WR_LOW_WM          = 4,
    parameter int WR_BURST_MAX       = 16,
    parameter int T_RD2WR            = 4,
    parameter int T_WR2RD            = 6,
    localparam int RCW  = $clog2(READCMDQUEUEDEPTH),
    localparam int WCW  = $clog2(WRITECMDQUEUEDEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUMRANK-1:0][RCW-1:0] readReqCnt,
    input  logic [NUMRANK-1:0][WCW-1:0] writeReqCnt,
    input  logic                       cmdIssued,
    output logic                       writeMode,
    output logic                       turnaroundBusy,
    output logic                       modeSwitch
`ifdef MODE_STATS_EN
    ,
    output logic [15:0]                switchCount,
    output logic [15:0]                starveExitCount
`endif
);

    localparam int RTW  = total_w(READCMDQUEUEDEPTH, NUMRANK);
    localparam int WTW  = total_w(WRITECMDQUEUEDEPTH, NUMRANK);
    localparam int CNTW = cnt_w(T_RD2WR, T_WR2RD, WR_BURST_MAX);

    generate
        if (!(WR_LOW_WM < WR_HIGH_WM)) begin : g_err_wm
            $error("WR_LOW_WM must be below WR_HIGH_WM");
        end
        if (WR_HIGH_WM > NUMRANK * (WRITECMDQUEUEDEPTH - 1)) begin : g_err_hi
            $error("WR_HIGH_WM unreachable");
        end
        if (T_RD2WR < 1 || T_WR2RD < 1) begin : g_err_t
            $error("turnaround times must be at least 1");
        end
    endgenerate

    logic [RTW-1:0]  w_rd_total;
    logic [WTW-1:0]  w_wr_total;
    logic [CNTW-1:0] w_burst_nxt;
    logic            w_cond_a;
    logic            w_cond_b;
    logic            w_cond_c;
    logic            w_rd_exit;
    logic            w_wr_exit;

    mode_state_e     r_state;
    logic [CNTW-1:0] r_tcnt;
    logic [CNTW-1:0] r_burst;
    logic            r_write_mode;
    logic            r_busy;
    logic            r_mode_switch;

    queue_occupancy_sum #(
        .NUMRANK (NUMRANK),
        .DEPTH   (READCMDQUEUEDEPTH)
    ) u_rd_sum (
        .i_cnt   (readReqCnt),
        .o_total (w_rd_total)
    );

    queue_occupancy_sum #(
        .NUMRANK (NUMRANK),
        .DEPTH   (WRITECMDQUEUEDEPTH)
    ) u_wr_sum (
        .i_cnt   (writeReqCnt),
        .o_total (w_wr_total)
    );

    always_comb begin
        w_burst_nxt = r_burst;
        if (cmdIssued && r_burst != CNTW'(WR_BURST_MAX)) begin
            w_burst_nxt = r_burst + CNTW'(1);
        end
        w_cond_a  = (w_wr_total == '0);
        w_cond_b  = (w_rd_total != '0) && (w_wr_total <= WTW'(WR_LOW_WM));
        w_cond_c  = (w_rd_total != '0) && (w_burst_nxt == CNTW'(WR_BURST_MAX));
        w_wr_exit = w_cond_a || w_cond_b || w_cond_c;
        w_rd_exit = (w_wr_total >= WTW'(WR_HIGH_WM)) ||
                    ((w_rd_total == '0) && (w_wr_total != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= MODE_READ;
            r_tcnt        <= '0;
            r_burst       <= '0;
            r_write_mode  <= 1'b0;
            r_busy        <= 1'b0;
            r_mode_switch <= 1'b0;
        end else begin
            r_mode_switch <= 1'b0;
            unique case (r_state)
                MODE_READ: begin
                    if (w_rd_exit) begin
                        r_state <= MODE_RD2WR;
                        r_busy  <= 1'b1;
                        r_tcnt  <= CNTW'(T_RD2WR - 1);
                    end
                end
                MODE_RD2WR: begin
                    if (r_tcnt == '0) begin
                        r_state       <= MODE_WRITE;
                        r_busy        <= 1'b0;
                        r_write_mode  <= 1'b1;
                        r_mode_switch <= 1'b1;
                        r_burst       <= '0;
                    end else begin
                        r_tcnt <= r_tcnt - CNTW'(1);
                    end
                end
                MODE_WRITE: begin
                    r_burst <= w_burst_nxt;
                    if (w_wr_exit) begin
                        r_state <= MODE_WR2RD;
                        r_busy  <= 1'b1;
                        r_tcnt  <= CNTW'(T_WR2RD - 1);
                    end
                end
                MODE_WR2RD: begin
                    if (r_tcnt == '0) begin
                        r_state       <= MODE_READ;
                        r_busy        <= 1'b0;
                        r_write_mode  <= 1'b0;
                        r_mode_switch <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt - CNTW'(1);
                    end
                end
                default: r_state <= MODE_READ;
            endcase
        end
    end

    assign writeMode      = r_write_mode;
    assign turnaroundBusy = r_busy;
    assign modeSwitch     = r_mode_switch;

`ifdef MODE_STATS_EN
    logic        w_switch;
    logic        w_starve;
    logic [15:0] r_switch_cnt;
    logic [15:0] r_starve_cnt;

    assign w_switch = (r_state == MODE_RD2WR || r_state == MODE_WR2RD) &&
                      (r_tcnt == '0);
    assign w_starve = (r_state == MODE_WRITE) && w_cond_c &&
                      !w_cond_a && !w_cond_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_switch_cnt <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_switch && r_switch_cnt != 16'hFFFF) begin
                r_switch_cnt <= r_switch_cnt + 16'd1;
            end
            if (w_starve && r_starve_cnt != 16'hFFFF) begin
                r_starve_cnt <= r_starve_cnt + 16'd1;
            end
        end
    end

    assign switchCount     = r_switch_cnt;
    assign starveExitCount = r_starve_cnt;
`endif

`ifndef SYNTHESIS
    // Grants must be held off while the bus turns around.
    always_ff @(posedge clk) begin
        if (!rst && r_busy) begin
            assert (!cmdIssued);
        end
    end
`endif

endmodule
